// File: rtl/masku_result_accumulator.sv
// Mask-unit result accumulator: ORs per-beat compressed compare bits into one
// DW-bit mask word, reports the running bit offset back to the operand stage,
// and hands each full or final word to the VRF write path.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   start_valid_i/ready  new mask-producing instruction (accepted in IDLE)
//   vl_i, vsew_i         vector length (elements), element width (0=EW8..3=EW64)
//   beat_valid_i/ready   compressed beat handshake (ready in ACCUM)
//   alu_cmp_i, bit_en_i  compressed compare bits and per-bit enables
//   vrf_pnt_o            bit offset of the next beat inside the current word
//   result_valid_i/ready mask word handshake (valid in FLUSH)
//   result_o, result_last_o  accumulated word, final-word flag
//   busy_o               instruction in flight
module masku_result_accumulator #(
  parameter int unsigned NrLanes = 4,
  parameter int unsigned VLEN    = 4096,
  localparam int unsigned ELEN   = 64,
  localparam int unsigned DW     = NrLanes * ELEN,
  localparam int unsigned VlW    = $clog2(VLEN) + 1,
  localparam int unsigned PntW   = $clog2(DW) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_valid_i,
  output logic            start_ready_o,
  input  logic [VlW-1:0]  vl_i,
  input  logic [1:0]      vsew_i,
  input  logic            beat_valid_i,
  output logic            beat_ready_o,
  input  logic [DW-1:0]   alu_cmp_i,
  input  logic [DW-1:0]   bit_en_i,
  output logic [PntW-1:0] vrf_pnt_o,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [DW-1:0]   result_o,
  output logic            result_last_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [PntW-1:0] pnt_q, pnt_d;
  logic [VlW-1:0]  rem_q, rem_d;
  logic [1:0]      vsew_q, vsew_d;

  logic            start_ready_q, beat_ready_q, valid_q, last_q, busy_q;

  logic [VlW-1:0]  epb;
  logic [VlW-1:0]  n_elem;
  logic [VlW-1:0]  pnt_sum;
  logic [VlW-1:0]  rem_next;

  // Elements consumed by one beat, clipped so remaining cannot underflow.
  always_comb begin
    epb      = VlW'(DW / 8) >> vsew_q;
    n_elem   = (rem_q < epb) ? rem_q : epb;
    pnt_sum  = VlW'(pnt_q) + n_elem;
    rem_next = rem_q - n_elem;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    pnt_d   = pnt_q;
    rem_d   = rem_q;
    vsew_d  = vsew_q;
    unique case (state_q)
      IDLE: begin
        if (start_valid_i) begin
          rem_d  = vl_i;
          acc_d  = '0;
          pnt_d  = '0;
          vsew_d = vsew_i;
          if (vl_i != '0) state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (beat_valid_i) begin
          acc_d = acc_q | (alu_cmp_i & bit_en_i);
          pnt_d = PntW'(pnt_sum);
          rem_d = rem_next;
          // Word is full, or the instruction has no more elements.
          if (pnt_sum == VlW'(DW) || rem_next == '0) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (result_ready_i) begin
          acc_d   = '0;
          pnt_d   = '0;
          state_d = (rem_q == '0) ? IDLE : ACCUM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and handshake registers; handshakes track the next state
  // so they line up with the state they describe.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      pnt_q         <= '0;
      rem_q         <= '0;
      vsew_q        <= '0;
      start_ready_q <= 1'b1;
      beat_ready_q  <= 1'b0;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      pnt_q         <= pnt_d;
      rem_q         <= rem_d;
      vsew_q        <= vsew_d;
      start_ready_q <= (state_d == IDLE);
      beat_ready_q  <= (state_d == ACCUM);
      valid_q       <= (state_d == FLUSH);
      last_q        <= (state_d == FLUSH) && (rem_d == '0);
      busy_q        <= (state_d != IDLE);
    end
  end

  assign start_ready_o  = start_ready_q;
  assign beat_ready_o   = beat_ready_q;
  assign result_valid_o = valid_q;
  assign result_last_o  = last_q;
  assign busy_o         = busy_q;
  assign result_o       = acc_q;
  assign vrf_pnt_o      = pnt_q;

endmodule

// File: tb/tb_masku_result_accumulator.sv
// Directed bench for masku_result_accumulator (NrLanes=4, DW=256).
module tb_masku_result_accumulator;

  localparam int unsigned DW   = 256;
  localparam int unsigned VlW  = 13;
  localparam int unsigned PntW = 9;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start_valid;
  logic            start_ready;
  logic [VlW-1:0]  vl;
  logic [1:0]      vsew;
  logic            beat_valid;
  logic            beat_ready;
  logic [DW-1:0]   alu_cmp;
  logic [DW-1:0]   bit_en;
  logic [PntW-1:0] vrf_pnt;
  logic            result_valid;
  logic            result_ready;
  logic [DW-1:0]   result;
  logic            result_last;
  logic            busy;

  int n_checks = 0;
  int n_pass   = 0;

  masku_result_accumulator #(.NrLanes(4), .VLEN(4096)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_valid_i  (start_valid),
    .start_ready_o  (start_ready),
    .vl_i           (vl),
    .vsew_i         (vsew),
    .beat_valid_i   (beat_valid),
    .beat_ready_o   (beat_ready),
    .alu_cmp_i      (alu_cmp),
    .bit_en_i       (bit_en),
    .vrf_pnt_o      (vrf_pnt),
    .result_valid_o (result_valid),
    .result_ready_i (result_ready),
    .result_o       (result),
    .result_last_o  (result_last),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int unsigned len, input logic [1:0] sew);
    start_valid = 1'b1;
    vl          = VlW'(len);
    vsew        = sew;
    step();
    start_valid = 1'b0;
  endtask

  task automatic do_beat(input logic [DW-1:0] cmp, input logic [DW-1:0] en);
    beat_valid = 1'b1;
    alu_cmp    = cmp;
    bit_en     = en;
    step();
    beat_valid = 1'b0;
    alu_cmp    = '0;
    bit_en     = '0;
  endtask

  task automatic do_handshake();
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] ones;
    logic [DW-1:0] exp_w;
    logic [DW-1:0] pat;
    ones = '1;

    rst_n = 1'b0; start_valid = 1'b0; vl = '0; vsew = '0;
    beat_valid = 1'b0; alu_cmp = '0; bit_en = '0; result_ready = 1'b0;
    step(); step();
    check("rst_valid", DW'(result_valid), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_pnt", DW'(vrf_pnt), DW'(0));
    check("rst_result", result, '0);
    check("rst_start_ready", DW'(start_ready), DW'(1));
    rst_n = 1'b1;
    step();

    // 1: single beat, vl=32 EW8
    do_start(32, 2'd0);
    check("t1_beat_ready", DW'(beat_ready), DW'(1));
    do_beat(ones, DW'(32'hFFFF_FFFF));
    check("t1_valid", DW'(result_valid), DW'(1));
    check("t1_result", result, DW'(32'hFFFF_FFFF));
    check("t1_last", DW'(result_last), DW'(1));
    check("t1_pnt", DW'(vrf_pnt), DW'(32));
    do_handshake();
    check("t1_idle_busy", DW'(busy), DW'(0));
    check("t1_idle_valid", DW'(result_valid), DW'(0));
    check("t1_idle_pnt", DW'(vrf_pnt), DW'(0));

    // 2: vl=256 EW8, eight beats fill exactly one word
    do_start(256, 2'd0);
    exp_w = '0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_pnt%0d", i), DW'(vrf_pnt), DW'(i * 32));
      check($sformatf("t2_novalid%0d", i), DW'(result_valid), DW'(0));
      pat = DW'(8'hA5) << (i * 32);
      exp_w = exp_w | pat;
      do_beat(pat | (pat << 8), DW'(8'hFF) << (i * 32));
    end
    check("t2_valid", DW'(result_valid), DW'(1));
    check("t2_result", result, exp_w);
    check("t2_last", DW'(result_last), DW'(1));
    do_handshake();
    check("t2_busy", DW'(busy), DW'(0));
    check("t2_valid_low", DW'(result_valid), DW'(0));

    // 3: vl=300 EW8 spans two words
    do_start(300, 2'd0);
    exp_w = '0;
    for (int i = 0; i < 8; i++) begin
      pat = DW'(1) << (i * 32 + i);
      exp_w = exp_w | pat;
      do_beat(pat, ones);
    end
    check("t3_w0_valid", DW'(result_valid), DW'(1));
    check("t3_w0_last", DW'(result_last), DW'(0));
    check("t3_w0_pnt", DW'(vrf_pnt), DW'(256));
    check("t3_w0_result", result, exp_w);
    do_handshake();
    check("t3_mid_pnt", DW'(vrf_pnt), DW'(0));
    check("t3_mid_beat_ready", DW'(beat_ready), DW'(1));
    do_beat(ones, DW'(32'hFFFF_FFFF));
    check("t3_b9_pnt", DW'(vrf_pnt), DW'(32));
    do_beat(ones, DW'(12'hFFF) << 32);
    check("t3_w1_valid", DW'(result_valid), DW'(1));
    check("t3_w1_pnt", DW'(vrf_pnt), DW'(44));
    check("t3_w1_last", DW'(result_last), DW'(1));
    check("t3_w1_result", result, (DW'(1) << 44) - DW'(1));
    do_handshake();
    check("t3_busy", DW'(busy), DW'(0));

    // 4: vl=8 EW64, backpressure holds the word
    do_start(8, 2'd3);
    do_beat(DW'(8'h0F), DW'(8'h0F));
    check("t4_pnt1", DW'(vrf_pnt), DW'(4));
    do_beat(DW'(8'hF0), DW'(8'hF0));
    for (int c = 0; c < 5; c++) begin
      start_valid = 1'b1; vl = VlW'(32); beat_valid = 1'b1;
      alu_cmp = ones; bit_en = ones;
      check($sformatf("t4_valid%0d", c), DW'(result_valid), DW'(1));
      check($sformatf("t4_result%0d", c), result, DW'(8'hFF));
      check($sformatf("t4_last%0d", c), DW'(result_last), DW'(1));
      check($sformatf("t4_beat_ready%0d", c), DW'(beat_ready), DW'(0));
      check($sformatf("t4_start_ready%0d", c), DW'(start_ready), DW'(0));
      check($sformatf("t4_pnt%0d", c), DW'(vrf_pnt), DW'(8));
      step();
    end
    start_valid = 1'b0; beat_valid = 1'b0; alu_cmp = '0; bit_en = '0;
    do_handshake();
    check("t4_busy", DW'(busy), DW'(0));
    check("t4_start_ready", DW'(start_ready), DW'(1));

    // 5: vl=0 start produces nothing
    do_start(0, 2'd0);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("t5_valid%0d", c), DW'(result_valid), DW'(0));
      check($sformatf("t5_busy%0d", c), DW'(busy), DW'(0));
      step();
    end
    check("t5_start_ready", DW'(start_ready), DW'(1));

    // 6: reset mid-operation, then a clean new instruction
    do_start(256, 2'd0);
    for (int i = 0; i < 3; i++) do_beat(ones, ones);
    check("t6_pnt_before", DW'(vrf_pnt), DW'(96));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t6_rst_valid", DW'(result_valid), DW'(0));
    check("t6_rst_busy", DW'(busy), DW'(0));
    check("t6_rst_pnt", DW'(vrf_pnt), DW'(0));
    check("t6_rst_result", result, '0);
    check("t6_rst_beat_ready", DW'(beat_ready), DW'(0));
    check("t6_rst_start_ready", DW'(start_ready), DW'(1));
    do_start(32, 2'd0);
    do_beat(DW'(32'h1234_5678), ones);
    check("t6_valid", DW'(result_valid), DW'(1));
    check("t6_result", result, DW'(32'h1234_5678));
    check("t6_last", DW'(result_last), DW'(1));
    do_handshake();
    check("t6_busy", DW'(busy), DW'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
